// File: rtl/bullet_scheduler.sv
// bullet_scheduler: player weapon bullet pool.
// A fire request allocates the lowest free slot once per frame, gated by a
// frame-tick cooldown. Every frame tick walks the slots one per clk, moving
// active bullets upward and retiring those that leave the top. Collision
// reports retire a slot immediately. A registered per-pixel hit test drives
// the VGA mixer.
// Optional feature: define BULLET_AUTOFIRE_EN to make fire level-sensitive
// (holding fire re-arms the request every clk); otherwise only a 0->1
// transition of fire arms a request.
module bullet_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int COOLDOWN  = 8,
    parameter int SPEED     = 4,
    parameter int BULLET_W  = 4,
    parameter int BULLET_H  = 16,
    parameter int X_OFF     = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    fire,
    input  logic [9:0]              p_x,
    input  logic [9:0]              p_y,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    hit_valid,
    input  logic [2:0]              hit_slot,
    output logic                    bullet_en,
    output logic [11:0]             bullet_rgb,
    output logic [NUM_SLOTS-1:0]    active_mask,
    output logic [NUM_SLOTS*10-1:0] slot_x,
    output logic [NUM_SLOTS*10-1:0] slot_y,
    output logic                    fire_ack
);

    localparam int IW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(COOLDOWN + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_SLOTS - 1);
    localparam logic [CW-1:0] COOLDOWN_V = CW'(COOLDOWN);
    localparam logic [9:0]    SPEED_V    = 10'(SPEED);
    localparam logic [9:0]    X_OFF_V    = 10'(X_OFF);
    localparam logic [9:0]    BH_V       = 10'(BULLET_H);
    localparam logic [10:0]   BW11       = 11'(BULLET_W);
    localparam logic [10:0]   BH11       = 11'(BULLET_H);
    localparam logic [3:0]    NUM_SLOTS_V = 4'(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_t;

    state_t               state;
    state_t               state_next;
    logic [IW-1:0]        idx;
    logic [CW-1:0]        cooldown;
    logic                 fire_pending;
    logic                 tick_pending;
    logic                 fire_prev;
    logic                 fire_req;

    logic [NUM_SLOTS-1:0] active;
    logic [9:0]           b_x [NUM_SLOTS];
    logic [9:0]           b_y [NUM_SLOTS];

    logic                 frame_start;
    logic                 upd_step;
    logic                 spawn_go;
    logic                 any_free;
    logic                 hit_ok;
    logic [NUM_SLOTS-1:0] free_onehot;
    logic [NUM_SLOTS-1:0] spawn_sel;
    logic [NUM_SLOTS-1:0] upd_sel;
    logic [NUM_SLOTS-1:0] hit_clr;
    logic [NUM_SLOTS-1:0] pix_hit;
    logic [9:0]           spawn_x;
    logic [9:0]           spawn_y;

`ifdef BULLET_AUTOFIRE_EN
    assign fire_req = fire;
`else
    assign fire_req = fire && !fire_prev;
`endif

    // Spawn position: x wraps in 10 bits, y saturates at the top edge.
    assign spawn_x = p_x + X_OFF_V;
    assign spawn_y = (p_y < BH_V) ? 10'd0 : (p_y - BH_V);

    // Out-of-range collision reports are ignored.
    assign hit_ok = ({1'b0, hit_slot} < NUM_SLOTS_V);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic: IDLE -> UPDATE (one slot per clk) -> SPAWN -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick || tick_pending) state_next = UPDATE;
            UPDATE:  if (idx == LAST_IDX) state_next = SPAWN;
            SPAWN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: frame start, per-slot update strobe, spawn decision.
    always_comb begin
        frame_start = 1'b0;
        upd_step    = 1'b0;
        spawn_go    = 1'b0;
        case (state)
            IDLE:    frame_start = tick || tick_pending;
            UPDATE:  upd_step    = 1'b1;
            SPAWN:   spawn_go    = fire_pending && (cooldown == '0) && any_free;
            default: ;
        endcase
    end

    // Lowest-index free slot as a one-hot vector.
    always_comb begin
        free_onehot = '0;
        any_free    = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_onehot    = '0;
                free_onehot[i] = 1'b1;
                any_free       = 1'b1;
            end
        end
    end

    assign spawn_sel = spawn_go ? free_onehot : '0;

    // Global control: slot index, cooldown, request latches, fire_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            cooldown     <= '0;
            fire_pending <= 1'b0;
            tick_pending <= 1'b0;
            fire_prev    <= 1'b0;
            fire_ack     <= 1'b0;
        end else begin
            fire_prev <= fire;
            fire_ack  <= spawn_go;

            if (frame_start)
                idx <= '0;
            else if (upd_step && idx != LAST_IDX)
                idx <= idx + 1'b1;

            if (spawn_go)
                cooldown <= COOLDOWN_V;
            else if (frame_start && cooldown != '0)
                cooldown <= cooldown - 1'b1;

            // A new request in the spawn clk re-arms, so autofire never loses a frame.
            if (fire_req)
                fire_pending <= 1'b1;
            else if (spawn_go)
                fire_pending <= 1'b0;

            // One-deep tick buffer while a frame update is in flight.
            if (tick && state != IDLE)
                tick_pending <= 1'b1;
            else if (frame_start)
                tick_pending <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign hit_clr[gi] = hit_valid && hit_ok && (hit_slot == 3'(gi));
            assign upd_sel[gi] = upd_step && (idx == IW'(gi));

            // Slot state: collision retire wins over spawn and frame update.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    active[gi] <= 1'b0;
                    b_x[gi]    <= '0;
                    b_y[gi]    <= '0;
                end else if (hit_clr[gi]) begin
                    active[gi] <= 1'b0;
                end else if (spawn_sel[gi]) begin
                    active[gi] <= 1'b1;
                    b_x[gi]    <= spawn_x;
                    b_y[gi]    <= spawn_y;
                end else if (upd_sel[gi] && active[gi]) begin
                    if (b_y[gi] < SPEED_V)
                        active[gi] <= 1'b0;
                    else
                        b_y[gi] <= b_y[gi] - SPEED_V;
                end
            end

            // Pixel coverage in 11 bits so a bullet at the right/bottom edge does not wrap.
            assign pix_hit[gi] = active[gi]
                && ({1'b0, x} >= {1'b0, b_x[gi]}) && ({1'b0, x} < ({1'b0, b_x[gi]} + BW11))
                && ({1'b0, y} >= {1'b0, b_y[gi]}) && ({1'b0, y} < ({1'b0, b_y[gi]} + BH11));

            assign slot_x[gi*10 +: 10] = b_x[gi];
            assign slot_y[gi*10 +: 10] = b_y[gi];
        end
    endgenerate

    assign active_mask = active;

    // Registered render output for the pixel presented one clk earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bullet_en  <= 1'b0;
            bullet_rgb <= 12'h000;
        end else begin
            bullet_en  <= |pix_hit;
            bullet_rgb <= (|pix_hit) ? 12'h00F : 12'h000;
        end
    end

endmodule
